soc_onchip_mem_arbiter: RTL
===========================

// Module: soc_onchip_mem_arbiter
// PURPOSE
//  Two-requester Avalon-MM arbiter that shares the single-port 64-bit on-chip RAM
//  (14-bit word address, 8 byte lanes, 1-cycle read latency) between two masters.
//  Typical masters: the Nios data master and a DMA/HPS bridge.
//  Issues at most one access per cycle and returns read data with readdatavalid.
//  Range-checks addresses and blocks new grants during freeze.
// PARAMETERS
//  DEPTH     12500          number of valid 64-bit words; addresses >= DEPTH are out of range
//  ERR_DATA  64'hDEAD_BEEF_DEAD_BEEF  readdata returned for an out-of-range read
// PORTS
//  clk              in   1   single clock for all logic
//  reset_n          in   1   asynchronous active-low reset
//  freeze           in   1   1 = grant no new accesses
//  rN_address       in   14  requester N (N=0,1) word address
//  rN_byteenable    in   8   requester N byte lanes (writes only)
//  rN_read          in   1   requester N read request
//  rN_write         in   1   requester N write request
//  rN_writedata     in   64  requester N write data
//  rN_waitrequest   out  1   1 = request not accepted this cycle
//  rN_readdata      out  64  read data, valid when rN_readdatavalid=1
//  rN_readdatavalid out  1   one-cycle read-return strobe
//  m_address        out  14  to RAM address
//  m_byteenable     out  8   to RAM byteenable
//  m_chipselect     out  1   to RAM chipselect
//  m_write          out  1   to RAM write
//  m_writedata      out  64  to RAM writedata
//  m_clken          out  1   to RAM clken, tied 1
//  m_readdata       in   64  from RAM, valid 1 cycle after the read is issued
// BEHAVIOUR
//  - Request: reqN = rN_read | rN_write. If both are 1, the access is a write (no read return).
//  - Grant (combinational, same cycle):
//      * only reqN -> grant N;
//      * both -> grant the requester that was not granted most recently (last_gnt).
//      * last_gnt updates on every grant.
//  - rN_waitrequest = reqN & ~(grantN). It is 0 when reqN=0.
//      * A request is accepted in the cycle its waitrequest is 0 while reqN=1.
//  - freeze=1: no grants. Every asserted reqN sees waitrequest=1.
//      * A read issued in the previous cycle still returns normally.
//  - Memory side: m_address/m_byteenable/m_writedata are muxed from the granted requester.
//      * Granted and address < DEPTH: m_chipselect=1, m_write=write.
//      * Granted and address >= DEPTH: m_chipselect=0. The write is dropped; the access is still accepted.
//      * No grant: m_chipselect=0 and m_write=0. Mux defaults to requester 0.
//      * m_byteenable is forced to 8'hFF on reads.
//  - Read return:
//      * An accepted read at cycle T registers rd_pend, rd_tag=N and rd_err=(addr>=DEPTH).
//      * At T+1: rN_readdatavalid=1 for tag N; rN_readdata = rd_err ? ERR_DATA : m_readdata.
//      * The non-tagged requester's readdatavalid=0. Latency is exactly 1 cycle.
//      * Back-to-back reads from either requester give one return per cycle.
//  - rN_readdata is held at its last value when not valid. Reset value is 64'h0.
//  - Reset (async, reset_n=0):
//      * last_gnt=1, so requester 0 wins the first conflict.
//      * rd_pend=0, rd_tag=0, rd_err=0; both readdatavalid=0; readdata=0.
//      * An in-flight read is discarded; no readdatavalid after reset is released.
//  - Outputs while in reset: waitrequest follows the grant logic with no grants, i.e. =reqN.
//      * m_chipselect=0, m_write=0, m_clken=1.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins a conflict; last_gnt unused.
//      * Requester 1 can starve.
//  Not defined: round-robin as above. No other behaviour changes.
// TESTING
//  1 Reset, then r0 write addr 5 be 8'h0F data 64'h1122334455667788, then r0 read addr 5
//      -> readdatavalid at T+1, data 64'h0000000055667788 (RAM pre-zeroed).
//  2 r0 and r1 both read every cycle for 6 cycles (round-robin)
//      -> grants alternate 0,1,0,1,0,1; each readdatavalid is tagged to its own requester.
//      -> each waitrequest is 1 on the cycles it loses.
//  3 r1 write to addr 12500 data 64'hFF..FF, then read addr 12500
//      -> m_chipselect stays 0; read returns ERR_DATA at T+1; addr 12499 remains unchanged.
//  4 Read accepted at T, freeze=1 from T+1 for 3 cycles with both requesting
//      -> read returns at T+1; waitrequest=1 for both for 3 cycles; grants resume after.
//  5 reset_n=0 in the cycle after a read is accepted
//      -> no readdatavalid; after release, the first conflict grants requester 0.
//  6 With MEM_ARB_FIXED_PRIO_EN defined, both requesting for 4 cycles
//      -> requester 0 granted 4/4; r1_waitrequest=1 throughout.

Source files
------------

// File: rtl/soc_onchip_mem_arbiter_if.sv
// Avalon-MM bundle between two requesters, the arbiter and a single-port 64-bit on-chip RAM.
// slave = arbiter view (serves requesters, drives RAM); master = requesters plus RAM.
interface soc_onchip_mem_arbiter_if;
    logic [13:0] r0_address;
    logic [7:0]  r0_byteenable;
    logic        r0_read;
    logic        r0_write;
    logic [63:0] r0_writedata;
    logic        r0_waitrequest;
    logic [63:0] r0_readdata;
    logic        r0_readdatavalid;

    logic [13:0] r1_address;
    logic [7:0]  r1_byteenable;
    logic        r1_read;
    logic        r1_write;
    logic [63:0] r1_writedata;
    logic        r1_waitrequest;
    logic [63:0] r1_readdata;
    logic        r1_readdatavalid;

    logic [13:0] m_address;
    logic [7:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [63:0] m_writedata;
    logic        m_clken;
    logic [63:0] m_readdata;

    modport slave (
        input  r0_address, r0_byteenable, r0_read, r0_write, r0_writedata,
        output r0_waitrequest, r0_readdata, r0_readdatavalid,
        input  r1_address, r1_byteenable, r1_read, r1_write, r1_writedata,
        output r1_waitrequest, r1_readdata, r1_readdatavalid,
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );

    modport master (
        output r0_address, r0_byteenable, r0_read, r0_write, r0_writedata,
        input  r0_waitrequest, r0_readdata, r0_readdatavalid,
        output r1_address, r1_byteenable, r1_read, r1_write, r1_writedata,
        input  r1_waitrequest, r1_readdata, r1_readdatavalid,
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );
endinterface

// File: rtl/soc_onchip_mem_arbiter.sv
// Two-requester arbiter for a single-port 64-bit on-chip RAM; round-robin, or fixed r0 priority with MEM_ARB_FIXED_PRIO_EN.
// Latency: grant same cycle, read data returned exactly 1 cycle after acceptance.
// Backpressure: losing/frozen requesters see waitrequest=1; out-of-range accesses are accepted but never reach the RAM.
module soc_onchip_mem_arbiter #(
    parameter int unsigned DEPTH    = 12500,
    parameter logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          freeze,
    soc_onchip_mem_arbiter_if.slave       bus
);

    logic        req0, req1;
    logic        gnt0, gnt1, gnt_any;
    logic        sel_write, in_range;
    logic [13:0] sel_addr;
    logic        rd_pend, rd_tag, rd_err;
    logic [63:0] rd_data, r0_hold, r1_hold;

    assign req0 = bus.r0_read | bus.r0_write;
    assign req1 = bus.r1_read | bus.r1_write;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !freeze) begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
        end
    end
`else
    logic last_gnt;

    // On a conflict, the requester that did not win most recently gets the grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !freeze) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= 1'b1;
        end else if (gnt_any) begin
            last_gnt <= gnt1;
        end
    end
`endif

    assign gnt_any   = gnt0 | gnt1;
    assign sel_addr  = gnt1 ? bus.r1_address : bus.r0_address;
    assign sel_write = gnt1 ? bus.r1_write   : bus.r0_write;
    assign in_range  = 32'(sel_addr) < DEPTH;

    assign bus.m_address    = sel_addr;
    assign bus.m_writedata  = gnt1 ? bus.r1_writedata : bus.r0_writedata;
    assign bus.m_byteenable = !sel_write ? 8'hFF : (gnt1 ? bus.r1_byteenable : bus.r0_byteenable);
    assign bus.m_chipselect = gnt_any & in_range;
    assign bus.m_write      = gnt_any & in_range & sel_write;
    assign bus.m_clken      = 1'b1;

    assign bus.r0_waitrequest = req0 & ~gnt0;
    assign bus.r1_waitrequest = req1 & ~gnt1;

    // Tag/error are captured every cycle; only rd_pend decides whether they matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            rd_pend <= gnt_any & ~sel_write;
            rd_tag  <= gnt1;
            rd_err  <= ~in_range;
        end
    end

    assign rd_data = rd_err ? ERR_DATA : bus.m_readdata;

    assign bus.r0_readdatavalid = rd_pend & ~rd_tag;
    assign bus.r1_readdatavalid = rd_pend &  rd_tag;
    assign bus.r0_readdata      = bus.r0_readdatavalid ? rd_data : r0_hold;
    assign bus.r1_readdata      = bus.r1_readdatavalid ? rd_data : r1_hold;

    // RAM data is only valid in the return cycle, so keep a copy for the idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r0_hold <= 64'h0;
            r1_hold <= 64'h0;
        end else begin
            if (bus.r0_readdatavalid) r0_hold <= rd_data;
            if (bus.r1_readdatavalid) r1_hold <= rd_data;
        end
    end

endmodule
